engine_alu_ops_pipe: RTL and testbench
======================================

# engine_alu_ops_pipe

Parametrised, flow-controlled ALU kernel for the engine datapath. Routes NUM_FIELDS input fields through a per-field operand crossbar with constant injection, then applies NOP/ADD/SUB/MUL/ACC under a valid/ready handshake with full back-pressure. Grouped accumulation emits one result per ACC_COUNT beats. Sits between the engine input FIFO and the engine output packer.

## Interface
Parameters:
- NUM_FIELDS, 4: fields per packet; even, ≥2.
- DATA_W, 32: bits per field.
- CNT_W, 16: width of the accumulate group counter.

Ports (reset areset, synchronous, active-high; clock ap_clk):
- ap_clk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- clear  in  1  synchronous flush of the pipeline and accumulator.
- cfg_valid  in  1  configuration valid.
- cfg_op  in  3  0=NOP, 1=ADD, 2=SUB, 3=MUL, 4=ACC; others behave as NOP.
- cfg_alu_mask  in  NUM_FIELDS  operand-pair / ACC field select.
- cfg_ops_mask  in  NUM_FIELDS*NUM_FIELDS  row i is a one-hot source select for operand i.
- cfg_const_mask  in  NUM_FIELDS  operand i ← cfg_const_value.
- cfg_const_value  in  DATA_W  injected constant.
- cfg_acc_count  in  CNT_W  beats per ACC group; 0 is treated as 1.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  NUM_FIELDS*DATA_W  field i at bits [i*DATA_W +: DATA_W].
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  NUM_FIELDS*DATA_W  result packet.
- out_sat  out  1  saturation occurred for this result.

## Operation
- FSM states:
  - IDLE → RUN when cfg_valid=1. All cfg_* inputs are latched on this transition.
  - RUN → DRAIN when cfg_valid=0.
  - DRAIN → IDLE when no pipeline stage is valid and the ACC group count is 0.
  - DRAIN → RUN when cfg_valid returns before the pipeline empties. Configuration is not re-latched.
- in_ready = (state==RUN) & advance, where advance = !out_valid | out_ready. All stages move together on advance and hold otherwise.
- Stage 1, operand select. Applied per operand i:
  - cfg_const_mask[i] set → operand i = const.
  - Otherwise operand i = in field j, where j is the set bit in row i. If several bits are set, the highest j wins. An all-zero row gives 0.
  - The routed value with no const substitution is kept as org[i].
- Stage 2, compute:
  - k = lowest set bit of cfg_alu_mask with k ≤ NUM_FIELDS-2. If there is none, k=0.
  - ADD: op[k]+op[k+1].
  - SUB: |op[k]-op[k+1]|.
  - MUL: low DATA_W bits of op[k]*op[k+1].
  - NOP: op[0].
  - ACC: acc ← acc + Σ op[i] over set cfg_alu_mask bits. Results wrap modulo 2^DATA_W.
- ACC grouping:
  - The counter increments on each accepted beat.
  - Stage 2 marks valid only on the beat that reaches cfg_acc_count. That beat emits acc+beat sum, then acc and the counter reset to 0.
  - Non-final beats produce no output.
- Stage 3, output packing:
  - Field 0 = result.
  - Fields 1..NUM_FIELDS/2-1 = 0.
  - Fields NUM_FIELDS/2..NUM_FIELDS-1 = org of the same index.
- clear: all stage valids, acc, the ACC counter and out_valid go to 0 next cycle. The FSM state is kept. An in-flight handshake in the clear cycle is dropped.
- Reset values: out_valid=0, out_data=0, out_sat=0, in_ready=0, state=IDLE, acc=0, counter=0.

## Timing
- Latency: accepted beat at cycle t → out_valid at t+3 when unstalled.
- Throughput: 1 beat/cycle while out_ready=1.
- ACC: one output per group, 3 cycles after the final beat.
- out_valid=1 with out_ready=0: out_data and out_sat are held stable. in_ready=0 the same cycle.
- Simultaneous clear and areset: areset dominates. The result is identical apart from the FSM state.
- cfg_* changes while in RUN or DRAIN are ignored until the next IDLE→RUN.

## Configuration
- ALU_OPS_SATURATE_EN defined:
  - ADD, MUL and ACC clamp to 2^DATA_W-1 on overflow and set out_sat with that result.
  - ACC saturation is sticky per group and clears on group emit.
- Undefined: all arithmetic wraps and out_sat is tied to 0.

## Test plan
- NOP/route: cfg_ops_mask rows {0:f3, 1:f2, 2:f1, 3:f0}, in={1,2,3,4} → out={4,0,2,1} at t+3.
- ADD with const: const_mask=0b0010, const=10, alu_mask=0b0001, in f0=5 → field0=15. SUB with in {3,9}, alu_mask=0b0001 → field0=6.
- ACC grouping: cfg_acc_count=4, alu_mask=0b0011, beats f0+f1={1,2,3,4} → exactly one output, field0=10. The next group starts from 0.
- Back-pressure: out_ready=0 for 5 cycles mid-stream of 8 NOP beats → no loss or duplication, out_data stable while stalled, in_ready=0 during the stall.
- Overflow: ADD 0xFFFFFFFF+2 → 0x00000001 with out_sat=0. With ALU_OPS_SATURATE_EN → 0xFFFFFFFF with out_sat=1.
- clear mid-group: after 2 of 4 ACC beats, assert clear. The next 4 beats {1,1,1,1} → field0=4. Drop cfg_valid → FSM reaches IDLE once the pipeline is empty.

Source files
------------

// File: rtl/engine_alu_ops_pipe.sv
// engine_alu_ops_pipe
// Flow-controlled ALU kernel placed between the engine input FIFO and the
// output packer. Each beat passes through a per-operand crossbar with
// constant injection (stage 1). A NOP/ADD/SUB/MUL/ACC compute follows in
// stage 2, and output packing in stage 3. All stages advance together
// whenever the output register is empty or being drained.
//
// Ports:
//   ap_clk, areset      clock, synchronous active-high reset
//   clear               synchronous flush of pipeline valids and accumulator
//   cfg_*               configuration, latched on the IDLE->RUN transition only
//   in_valid/in_ready   input handshake, in_data field i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready output handshake, out_data packed result, out_sat flag
//
// Build option: define ALU_OPS_SATURATE_EN so that ADD, MUL and ACC clamp to
// all-ones on overflow and raise out_sat. Without it, all arithmetic wraps
// and out_sat stays 0.
module engine_alu_ops_pipe #(
    parameter int NUM_FIELDS = 4,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         clear,
    input  logic                         cfg_valid,
    input  logic [2:0]                   cfg_op,
    input  logic [NUM_FIELDS-1:0]        cfg_alu_mask,
    input  logic [NUM_FIELDS*NUM_FIELDS-1:0] cfg_ops_mask,
    input  logic [NUM_FIELDS-1:0]        cfg_const_mask,
    input  logic [DATA_W-1:0]            cfg_const_value,
    input  logic [CNT_W-1:0]             cfg_acc_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic                         out_sat
);

    localparam int NF = NUM_FIELDS;
    localparam int KW = $clog2(NF);
    localparam int SW = DATA_W + $clog2(NF) + 1;   // room for acc + NF operands
`ifdef ALU_OPS_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [2:0] OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_ACC = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                      r_state, w_state_nxt;
    logic                        w_run;

    logic [2:0]                  r_cfg_op;
    logic [NF-1:0]               r_cfg_alu, r_cfg_const;
    logic [NF*NF-1:0]            r_cfg_ops;
    logic [DATA_W-1:0]           r_cfg_cval;
    logic [CNT_W-1:0]            r_cfg_cnt;

    logic [3:1]                  r_vld_pipe;
    logic [NF-1:0][DATA_W-1:0]   w_in, w_route, w_ops;
    logic [NF-1:0][DATA_W-1:0]   r_s1_ops, r_s1_org, r_s2_org, r_out_data;
    logic [DATA_W-1:0]           r_s2_res, r_acc, w_res, w_a, w_b, w_sub;
    logic                        r_s2_sat, r_out_sat, r_acc_sat, w_sat;
    logic [CNT_W-1:0]            r_cnt, w_tgt;
    logic [KW-1:0]               w_k, w_k1;
    logic [DATA_W:0]             w_add_full;
    logic [2*DATA_W-1:0]         w_mul_full;
    logic [SW-1:0]               w_acc_full;
    logic                        w_acc_ovf, w_advance, w_accept, w_is_acc, w_final;

    // ---------------- FSM ----------------
    always_ff @(posedge ap_clk) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cfg_valid) w_state_nxt = S_RUN;
            S_RUN:   if (!cfg_valid) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                // Returning cfg_valid resumes with the existing configuration.
                if (cfg_valid)                           w_state_nxt = S_RUN;
                else if (~|r_vld_pipe && r_cnt == '0)    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_run = (r_state == S_RUN);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_cfg_op    <= '0;
            r_cfg_alu   <= '0;
            r_cfg_const <= '0;
            r_cfg_ops   <= '0;
            r_cfg_cval  <= '0;
            r_cfg_cnt   <= '0;
        end else if (r_state == S_IDLE && cfg_valid) begin
            r_cfg_op    <= cfg_op;
            r_cfg_alu   <= cfg_alu_mask;
            r_cfg_const <= cfg_const_mask;
            r_cfg_ops   <= cfg_ops_mask;
            r_cfg_cval  <= cfg_const_value;
            r_cfg_cnt   <= cfg_acc_count;
        end
    end

    // ---------------- handshake ----------------
    assign out_valid = r_vld_pipe[3];
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign w_advance = !r_vld_pipe[3] | out_ready;
    assign in_ready  = w_run & w_advance;
    assign w_accept  = in_valid & in_ready & !clear;
    assign w_in      = in_data;

    // ---------------- stage 1: operand crossbar ----------------
    always_comb begin
        for (int i = 0; i < NF; i++) begin
            w_route[i] = '0;
            // Ascending scan: the highest set source bit wins.
            for (int j = 0; j < NF; j++)
                if (r_cfg_ops[i*NF+j]) w_route[i] = w_in[j];
            w_ops[i] = r_cfg_const[i] ? r_cfg_cval : w_route[i];
        end
    end

    // ---------------- stage 2: compute ----------------
    always_comb begin
        w_k = '0;
        // Descending scan leaves the lowest eligible bit; the top field cannot start a pair.
        for (int i = NF-2; i >= 0; i--)
            if (r_cfg_alu[i]) w_k = KW'(i);
    end

    assign w_k1       = w_k + KW'(1);
    assign w_a        = r_s1_ops[w_k];
    assign w_b        = r_s1_ops[w_k1];
    assign w_add_full = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub      = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_mul_full = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};

    always_comb begin
        w_acc_full = {{(SW-DATA_W){1'b0}}, r_acc};
        for (int i = 0; i < NF; i++)
            if (r_cfg_alu[i]) w_acc_full = w_acc_full + {{(SW-DATA_W){1'b0}}, r_s1_ops[i]};
    end
    assign w_acc_ovf = |w_acc_full[SW-1:DATA_W];

    always_comb begin
        w_res = r_s1_ops[0];
        w_sat = 1'b0;
        case (r_cfg_op)
            OP_ADD: begin
                w_res = w_add_full[DATA_W-1:0];
                if (SAT_EN && w_add_full[DATA_W]) begin w_res = '1; w_sat = 1'b1; end
            end
            OP_SUB: w_res = w_sub;
            OP_MUL: begin
                w_res = w_mul_full[DATA_W-1:0];
                if (SAT_EN && |w_mul_full[2*DATA_W-1:DATA_W]) begin w_res = '1; w_sat = 1'b1; end
            end
            OP_ACC: begin
                w_res = w_acc_full[DATA_W-1:0];
                if (SAT_EN && w_acc_ovf) w_res = '1;
                // Saturation stays flagged for the rest of the group.
                w_sat = SAT_EN && (r_acc_sat || w_acc_ovf);
            end
            default: ;
        endcase
    end

    assign w_is_acc = (r_cfg_op == OP_ACC);
    assign w_tgt    = (r_cfg_cnt == '0) ? CNT_W'(1) : r_cfg_cnt;
    assign w_final  = ((r_cnt + CNT_W'(1)) == w_tgt);

    // ---------------- pipeline registers ----------------
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_vld_pipe <= '0;
            r_s1_ops   <= '0;
            r_s1_org   <= '0;
            r_s2_org   <= '0;
            r_s2_res   <= '0;
            r_s2_sat   <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_acc      <= '0;
            r_acc_sat  <= 1'b0;
            r_cnt      <= '0;
        end else if (clear) begin
            r_vld_pipe <= '0;
            r_acc      <= '0;
            r_acc_sat  <= 1'b0;
            r_cnt      <= '0;
        end else if (w_advance) begin
            r_vld_pipe[1] <= w_accept;
            if (w_accept) begin
                r_s1_ops <= w_ops;
                r_s1_org <= w_route;
            end

            // Non-final ACC beats update the accumulator but create no output.
            r_vld_pipe[2] <= r_vld_pipe[1] & (!w_is_acc | w_final);
            if (r_vld_pipe[1]) begin
                r_s2_res <= w_res;
                r_s2_sat <= w_sat;
                r_s2_org <= r_s1_org;
                if (w_is_acc) begin
                    if (w_final) begin
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_acc     <= w_res;
                        r_acc_sat <= w_sat;
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end
            end

            r_vld_pipe[3] <= r_vld_pipe[2];
            if (r_vld_pipe[2]) begin
                for (int i = 0; i < NF; i++)
                    r_out_data[i] <= (i == 0) ? r_s2_res : (i < NF/2) ? '0 : r_s2_org[i];
                r_out_sat <= r_s2_sat;
            end
        end
    end

endmodule

// File: tb/tb_engine_alu_ops_pipe.sv
// Scoreboard bench for engine_alu_ops_pipe: expected packets are queued as
// beats are accepted and compared as the DUT emits them.
module tb_engine_alu_ops_pipe;

    localparam int NF = 4, DW = 32, CW = 16, PW = NF*DW;
`ifdef ALU_OPS_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            ap_clk = 1'b0;
    logic            areset = 1'b1, clear = 1'b0, cfg_valid = 1'b0;
    logic [2:0]      cfg_op = '0;
    logic [NF-1:0]   cfg_alu_mask = '0, cfg_const_mask = '0;
    logic [NF*NF-1:0] cfg_ops_mask = '0;
    logic [DW-1:0]   cfg_const_value = '0;
    logic [CW-1:0]   cfg_acc_count = '0;
    logic            in_valid = 1'b0, in_ready;
    logic [PW-1:0]   in_data = '0;
    logic            out_valid, out_ready = 1'b1, out_sat;
    logic [PW-1:0]   out_data;

    engine_alu_ops_pipe #(.NUM_FIELDS(NF), .DATA_W(DW), .CNT_W(CW)) dut (
        .ap_clk(ap_clk), .areset(areset), .clear(clear), .cfg_valid(cfg_valid),
        .cfg_op(cfg_op), .cfg_alu_mask(cfg_alu_mask), .cfg_ops_mask(cfg_ops_mask),
        .cfg_const_mask(cfg_const_mask), .cfg_const_value(cfg_const_value),
        .cfg_acc_count(cfg_acc_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat));

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [PW-1:0] data;
        logic          sat;
        int            t;
        bit            lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pk(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    initial forever begin
        @(posedge ap_clk);
        cyc++;
    end

    // Output monitor: pops the scoreboard on each output handshake and
    // checks hold behaviour while the output is stalled.
    initial begin
        logic [PW-1:0] held;
        logic          held_sat;
        bit            was_stall;
        exp_t          e;
        was_stall = 0;
        forever begin
            @(negedge ap_clk);
            if (!areset) begin
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", in_ready, 1'b0);
                    if (was_stall) begin
                        chk("stall_data", out_data, held);
                        chk("stall_sat", out_sat, held_sat);
                    end
                    held = out_data; held_sat = out_sat; was_stall = 1;
                end else begin
                    was_stall = 0;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) chk("unexpected_out", out_data, '0 ^ {PW{1'bx}});
                    else begin
                        e = sb_q.pop_front();
                        chk("data", out_data, e.data);
                        chk("sat", out_sat, e.sat);
                        if (e.lat) chk("latency", cyc - e.t, 3);
                    end
                end
            end
        end
    end

    task automatic send(input logic [PW-1:0] d, input bit push, input logic [PW-1:0] ed,
                        input logic es, input bit lat);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge ap_clk);
        while (!in_ready && n < 50) begin n++; @(negedge ap_clk); end
        if (!in_ready) chk("in_ready_timeout", 1'b0, 1'b1);
        else if (push) sb_q.push_back('{ed, es, cyc, lat});
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin n++; @(posedge ap_clk); end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    task automatic reconfig(input logic [2:0] op, input logic [NF-1:0] alu, input logic [NF*NF-1:0] ops,
                            input logic [NF-1:0] cm, input logic [DW-1:0] cv, input logic [CW-1:0] cnt);
        wait_drain();
        cfg_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1;
        cfg_op = op; cfg_alu_mask = alu; cfg_ops_mask = ops;
        cfg_const_mask = cm; cfg_const_value = cv; cfg_acc_count = cnt;
        cfg_valid = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", out_sat, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge ap_clk); #1;
        areset = 1'b0;

        // Crossbar routing: operand i takes field 3-i.
        reconfig(3'd0, 4'b0001, 16'h1248, 4'b0000, 32'd0, 16'd1);
        send(pk(1, 2, 3, 4), 1, pk(4, 0, 2, 1), 1'b0, 1);
        send(pk(10, 20, 30, 40), 1, pk(40, 0, 20, 10), 1'b0, 1);

        // ADD with operand 1 replaced by the constant.
        reconfig(3'd1, 4'b0001, 16'h8401, 4'b0010, 32'd10, 16'd1);
        send(pk(5, 7, 8, 9), 1, pk(15, 0, 8, 9), 1'b0, 1);

        // ADD overflow.
        reconfig(3'd1, 4'b0001, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(3, 4, 0, 0), 1, pk(7, 0, 0, 0), 1'b0, 1);
        send(pk(32'hFFFF_FFFF, 2, 5, 6), 1, pk(SAT ? 32'hFFFF_FFFF : 32'h1, 0, 5, 6), SAT, 1);

        // SUB is an absolute difference; pair index follows the lowest usable mask bit.
        reconfig(3'd2, 4'b0001, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(3, 9, 0, 0), 1, pk(6, 0, 0, 0), 1'b0, 1);
        send(pk(9, 3, 1, 2), 1, pk(6, 0, 1, 2), 1'b0, 1);
        reconfig(3'd2, 4'b1000, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(20, 5, 1, 2), 1, pk(15, 0, 1, 2), 1'b0, 1);
        reconfig(3'd2, 4'b0110, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(0, 4, 10, 0), 1, pk(6, 0, 10, 0), 1'b0, 1);

        // MUL on pair (2,3), including overflow.
        reconfig(3'd3, 4'b1100, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(0, 0, 6, 7), 1, pk(42, 0, 6, 7), 1'b0, 1);
        send(pk(0, 0, 32'h10000, 32'h10000), 1,
             pk(SAT ? 32'hFFFF_FFFF : 32'h0, 0, 32'h10000, 32'h10000), SAT, 1);

        // Unassigned opcode behaves as NOP.
        reconfig(3'd5, 4'b0001, 16'h8421, 4'b0000, 32'd0, 16'd1);
        send(pk(11, 22, 33, 44), 1, pk(11, 0, 33, 44), 1'b0, 1);

        // ACC groups of 4 over fields 0 and 1.
        reconfig(3'd4, 4'b0011, 16'h8421, 4'b0000, 32'd0, 16'd4);
        send(pk(1, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(1, 1, 0, 0), 0, '0, 1'b0, 0);
        send(pk(2, 1, 0, 0), 0, '0, 1'b0, 0);
        send(pk(4, 0, 5, 6), 1, pk(10, 0, 5, 6), 1'b0, 1);
        send(pk(32'hFFFF_FFFF, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(2, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(0, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(0, 0, 7, 8), 1, pk(SAT ? 32'hFFFF_FFFF : 32'h1, 0, 7, 8), SAT, 1);
        for (int i = 0; i < 3; i++) send(pk(1, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(1, 0, 3, 4), 1, pk(4, 0, 3, 4), 1'b0, 1);

        // clear mid-group, with a handshake offered in the clear cycle.
        send(pk(5, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(5, 0, 0, 0), 0, '0, 1'b0, 0);
        repeat (3) @(posedge ap_clk);
        #1;
        clear = 1'b1; in_valid = 1'b1; in_data = pk(100, 0, 0, 0);
        @(posedge ap_clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send(pk(1, 0, 0, 0), 0, '0, 1'b0, 0);
        send(pk(1, 0, 0, 0), 1, pk(4, 0, 0, 0), 1'b0, 1);

        // A fresh configuration only takes effect if the FSM went back to IDLE.
        reconfig(3'd0, 4'b0001, 16'h1248, 4'b0000, 32'd0, 16'd1);
        send(pk(1, 2, 3, 4), 1, pk(4, 0, 2, 1), 1'b0, 1);

        // acc_count of 0 emits every beat.
        reconfig(3'd4, 4'b0001, 16'h8421, 4'b0000, 32'd0, 16'd0);
        send(pk(7, 1, 2, 3), 1, pk(7, 0, 2, 3), 1'b0, 1);
        send(pk(8, 1, 2, 3), 1, pk(8, 0, 2, 3), 1'b0, 1);

        // Back-pressure over 8 NOP beats; cfg_op change in RUN must be ignored.
        reconfig(3'd0, 4'b0001, 16'h8421, 4'b0000, 32'd0, 16'd1);
        cfg_op = 3'd1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(pk(i+1, 32'h10+i, 32'h20+i, 32'h30+i), 1,
                         pk(i+1, 0, 32'h20+i, 32'h30+i), 1'b0, 0);
            end
            begin
                repeat (4) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join

        wait_drain();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
